// File: rtl/hardwired_control_unit_if.sv
// Control-unit <-> datapath strobe bundle. The master side is the sequencer; the slave side is
// the datapath, which supplies the latched IR and the memory-ready handshake.
interface hardwired_control_unit_if #(
  parameter int unsigned OPC_W = 5,
  parameter int unsigned NREG  = 16
);
  logic [31:0]      i_ir;
  logic             i_mem_ready;

  logic             o_pc_out;
  logic             o_mar_in;
  logic             o_inc_pc;
  logic             o_pc_in;
  logic             o_read;
  logic             o_mdr_in;
  logic             o_mdr_out;
  logic             o_ir_in;
  logic             o_y_in;
  logic             o_z_in;
  logic             o_zlow_out;
  logic             o_zhigh_out;
  logic             o_hi_in;
  logic             o_lo_in;
  logic [NREG-1:0]  o_reg_in_en;
  logic [NREG-1:0]  o_reg_out_en;
  logic [OPC_W-1:0] o_alu_op;
  logic             o_run;
  logic             o_illegal;

  modport master (
    input  i_ir, i_mem_ready,
    output o_pc_out, o_mar_in, o_inc_pc, o_pc_in, o_read, o_mdr_in, o_mdr_out, o_ir_in,
           o_y_in, o_z_in, o_zlow_out, o_zhigh_out, o_hi_in, o_lo_in,
           o_reg_in_en, o_reg_out_en, o_alu_op, o_run, o_illegal
  );

  modport slave (
    output i_ir, i_mem_ready,
    input  o_pc_out, o_mar_in, o_inc_pc, o_pc_in, o_read, o_mdr_in, o_mdr_out, o_ir_in,
           o_y_in, o_z_in, o_zlow_out, o_zhigh_out, o_hi_in, o_lo_in,
           o_reg_in_en, o_reg_out_en, o_alu_op, o_run, o_illegal
  );
endinterface

// File: rtl/hardwired_control_unit.sv
// Hardwired fetch/execute sequencer for the bus-based datapath. Fetch runs T0-T2; execute
// runs T3-T6 with strobes decoded from the state and the latched instruction register.
module hardwired_control_unit #(
  parameter int unsigned OPC_W = 5,
  parameter int unsigned NREG  = 16
) (
  input  logic                      i_clock,
  input  logic                      i_clear,
  hardwired_control_unit_if.master  bus
);

  localparam int unsigned RegW = $clog2(NREG);
  localparam int unsigned RaHi = 31 - OPC_W;
  localparam int unsigned RbHi = RaHi - RegW;
  localparam int unsigned RcHi = RbHi - RegW;

  localparam logic [OPC_W-1:0] OpcAluLo = OPC_W'(3);
  localparam logic [OPC_W-1:0] OpcAluHi = OPC_W'(12);
  localparam logic [OPC_W-1:0] OpcMul   = OPC_W'(15);
  localparam logic [OPC_W-1:0] OpcDiv   = OPC_W'(16);
  localparam logic [OPC_W-1:0] OpcNop   = OPC_W'(26);
  localparam logic [OPC_W-1:0] OpcHalt  = OPC_W'(27);

  typedef enum logic [3:0] {
    StRst,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalt
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [OPC_W-1:0] w_opc;
  logic [RegW-1:0]  w_ra;
  logic [RegW-1:0]  w_rb;
  logic [RegW-1:0]  w_rc;
  logic [NREG-1:0]  w_one;
  logic [NREG-1:0]  w_ra_oh;
  logic [NREG-1:0]  w_rb_oh;
  logic [NREG-1:0]  w_rc_oh;
  logic             w_is_alu;
  logic             w_is_muldiv;
  logic             w_is_nop;
  logic             w_is_halt;
  logic             w_unused_ir;

  assign w_opc = bus.i_ir[31 -: OPC_W];
  assign w_ra  = bus.i_ir[RaHi -: RegW];
  assign w_rb  = bus.i_ir[RbHi -: RegW];
  assign w_rc  = bus.i_ir[RcHi -: RegW];

  // Low immediate/unused instruction bits are not consumed by this sequencer.
  assign w_unused_ir = ^bus.i_ir[RcHi-RegW:0];

  assign w_one   = {{(NREG-1){1'b0}}, 1'b1};
  assign w_ra_oh = w_one << w_ra;
  assign w_rb_oh = w_one << w_rb;
  assign w_rc_oh = w_one << w_rc;

  assign w_is_alu    = (w_opc >= OpcAluLo) && (w_opc <= OpcAluHi);
  assign w_is_muldiv = (w_opc == OpcMul) || (w_opc == OpcDiv);
  assign w_is_nop    = (w_opc == OpcNop);
  assign w_is_halt   = (w_opc == OpcHalt);

  always_ff @(posedge i_clock or posedge i_clear) begin
    if (i_clear) begin
      r_state <= StRst;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    bus.o_pc_out     = 1'b0;
    bus.o_mar_in     = 1'b0;
    bus.o_inc_pc     = 1'b0;
    bus.o_pc_in      = 1'b0;
    bus.o_read       = 1'b0;
    bus.o_mdr_in     = 1'b0;
    bus.o_mdr_out    = 1'b0;
    bus.o_ir_in      = 1'b0;
    bus.o_y_in       = 1'b0;
    bus.o_z_in       = 1'b0;
    bus.o_zlow_out   = 1'b0;
    bus.o_zhigh_out  = 1'b0;
    bus.o_hi_in      = 1'b0;
    bus.o_lo_in      = 1'b0;
    bus.o_reg_in_en  = '0;
    bus.o_reg_out_en = '0;
    bus.o_alu_op     = '0;
    bus.o_run        = 1'b1;
    bus.o_illegal    = 1'b0;

    unique case (r_state)
      StRst: begin
        bus.o_run    = 1'b0;
        w_state_next = StT0;
      end
      StT0: begin
        bus.o_pc_out = 1'b1;
        bus.o_mar_in = 1'b1;
        bus.o_inc_pc = 1'b1;
        bus.o_z_in   = 1'b1;
        w_state_next = StT1;
      end
      StT1: begin
        // Read request is held across wait cycles; the PC update waits for the data.
        bus.o_read   = 1'b1;
        bus.o_mdr_in = 1'b1;
        if (bus.i_mem_ready) begin
          bus.o_zlow_out = 1'b1;
          bus.o_pc_in    = 1'b1;
          w_state_next   = StT2;
        end
      end
      StT2: begin
        bus.o_mdr_out = 1'b1;
        bus.o_ir_in   = 1'b1;
        w_state_next  = StT3;
      end
      StT3: begin
        if (w_is_alu || w_is_muldiv) begin
          bus.o_reg_out_en = w_rb_oh;
          bus.o_y_in       = 1'b1;
          w_state_next     = StT4;
        end else if (w_is_halt) begin
          w_state_next = StHalt;
        end else begin
          bus.o_illegal = ~w_is_nop;
          w_state_next  = StT0;
        end
      end
      StT4: begin
        bus.o_reg_out_en = w_rc_oh;
        bus.o_alu_op     = w_opc;
        bus.o_z_in       = 1'b1;
        w_state_next     = StT5;
      end
      StT5: begin
        bus.o_zlow_out = 1'b1;
        if (w_is_muldiv) begin
          bus.o_lo_in  = 1'b1;
          w_state_next = StT6;
        end else begin
          bus.o_reg_in_en = w_ra_oh;
          w_state_next    = StT0;
        end
      end
      StT6: begin
        bus.o_zhigh_out = 1'b1;
        bus.o_hi_in     = 1'b1;
        w_state_next    = StT0;
      end
      StHalt: begin
        bus.o_run = 1'b0;
      end
      default: begin
        bus.o_run    = 1'b0;
        w_state_next = StRst;
      end
    endcase
  end

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Directed per-cycle vector table for the control unit, followed by a random legal
// instruction stream with bus-exclusivity and latency checks.
module tb_hardwired_control_unit;

  localparam logic [13:0] PcOut   = 14'h2000;
  localparam logic [13:0] MarIn   = 14'h1000;
  localparam logic [13:0] IncPc   = 14'h0800;
  localparam logic [13:0] PcIn    = 14'h0400;
  localparam logic [13:0] Rd      = 14'h0200;
  localparam logic [13:0] MdrIn   = 14'h0100;
  localparam logic [13:0] MdrOut  = 14'h0080;
  localparam logic [13:0] IrIn    = 14'h0040;
  localparam logic [13:0] YIn     = 14'h0020;
  localparam logic [13:0] ZIn     = 14'h0010;
  localparam logic [13:0] ZlowOut = 14'h0008;
  localparam logic [13:0] ZhiOut  = 14'h0004;
  localparam logic [13:0] HiIn    = 14'h0002;
  localparam logic [13:0] LoIn    = 14'h0001;

  localparam logic [13:0] T0s = PcOut | MarIn | IncPc | ZIn;
  localparam logic [13:0] T1w = Rd | MdrIn;
  localparam logic [13:0] T1r = ZlowOut | PcIn | Rd | MdrIn;
  localparam logic [13:0] T2s = MdrOut | IrIn;

  localparam logic [31:0] IrAlu = 32'h2891_8000;  // opc 5, Ra 1, Rb 2, Rc 3
  localparam logic [31:0] IrMul = 32'h7832_0000;  // opc 15, Ra 0, Rb 6, Rc 4
  localparam logic [31:0] IrIll = 32'hF800_0000;
  localparam logic [31:0] IrNop = 32'hD000_0000;
  localparam logic [31:0] IrHlt = 32'hD800_0000;

  typedef struct packed {
    logic        clr;
    logic [31:0] ir;
    logic        mr;
    logic [13:0] stb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu;
    logic        run;
    logic        ill;
  } vec_t;

  logic clock;
  logic clear;
  int   checks;
  int   errors;
  vec_t vecs[$];

  hardwired_control_unit_if u_if ();

  hardwired_control_unit u_dut (
    .i_clock (clock),
    .i_clear (clear),
    .bus     (u_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [52:0] actual();
    return {u_if.o_pc_out, u_if.o_mar_in, u_if.o_inc_pc, u_if.o_pc_in, u_if.o_read,
            u_if.o_mdr_in, u_if.o_mdr_out, u_if.o_ir_in, u_if.o_y_in, u_if.o_z_in,
            u_if.o_zlow_out, u_if.o_zhigh_out, u_if.o_hi_in, u_if.o_lo_in,
            u_if.o_reg_in_en, u_if.o_reg_out_en, u_if.o_alu_op, u_if.o_run, u_if.o_illegal};
  endfunction

  function automatic logic [31:0] mk_ir(input int opc, input int ra, input int rb, input int rc);
    return (32'(opc) << 27) | (32'(ra) << 23) | (32'(rb) << 19) | (32'(rc) << 15);
  endfunction

  task automatic add(input logic c, input logic [31:0] ir, input logic mr, input logic [13:0] s,
                     input logic [15:0] ri, input logic [15:0] ro, input logic [4:0] a,
                     input logic rn, input logic il);
    vec_t v;
    v.clr = c; v.ir = ir; v.mr = mr; v.stb = s; v.rin = ri; v.rout = ro;
    v.alu = a; v.run = rn; v.ill = il;
    vecs.push_back(v);
  endtask

  task automatic check_inv();
    int drv;
    drv = int'(u_if.o_pc_out) + int'(u_if.o_mdr_out) + int'(u_if.o_zlow_out) +
          int'(u_if.o_zhigh_out) + int'(|u_if.o_reg_out_en);
    checks++;
    if (drv > 1 || !$onehot0(u_if.o_reg_in_en) || !$onehot0(u_if.o_reg_out_en)) begin
      errors++;
      $display("FAIL invariant: drivers=%0d rin=%h rout=%h, required drivers<=1 and one-hot/zero",
               drv, u_if.o_reg_in_en, u_if.o_reg_out_en);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [52:0] exp_o;
    logic [52:0] act_o;
    int n;
    int cnt;
    int w;
    int base;
    int cls;
    int opc;

    checks = 0;
    errors = 0;

    add(1, IrAlu, 1, '0,      '0,       '0,       5'd0,  0, 0);  // clear held
    add(0, IrAlu, 1, '0,      '0,       '0,       5'd0,  0, 0);  // RST
    add(0, IrAlu, 1, T0s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrAlu, 1, T1r,     '0,       '0,       5'd0,  1, 0);
    add(0, IrAlu, 1, T2s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrAlu, 1, YIn,     '0,       16'h0004, 5'd0,  1, 0);
    add(0, IrAlu, 1, ZIn,     '0,       16'h0008, 5'd5,  1, 0);
    add(0, IrAlu, 1, ZlowOut, 16'h0002, '0,       5'd0,  1, 0);
    add(0, IrMul, 1, T0s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrMul, 0, T1w,     '0,       '0,       5'd0,  1, 0);  // three wait cycles
    add(0, IrMul, 0, T1w,     '0,       '0,       5'd0,  1, 0);
    add(0, IrMul, 0, T1w,     '0,       '0,       5'd0,  1, 0);
    add(0, IrMul, 1, T1r,     '0,       '0,       5'd0,  1, 0);
    add(0, IrMul, 1, T2s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrMul, 1, YIn,     '0,       16'h0040, 5'd0,  1, 0);
    add(0, IrMul, 1, ZIn,     '0,       16'h0010, 5'd15, 1, 0);
    add(0, IrMul, 1, ZlowOut | LoIn, '0, '0,      5'd0,  1, 0);
    add(0, IrMul, 1, ZhiOut | HiIn,  '0, '0,      5'd0,  1, 0);
    add(0, IrMul, 1, T0s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrIll, 1, T1r,     '0,       '0,       5'd0,  1, 0);
    add(0, IrIll, 1, T2s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrIll, 1, '0,      '0,       '0,       5'd0,  1, 1);
    add(0, IrIll, 1, T0s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrNop, 1, T1r,     '0,       '0,       5'd0,  1, 0);
    add(0, IrNop, 1, T2s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrNop, 1, '0,      '0,       '0,       5'd0,  1, 0);
    add(0, IrNop, 1, T0s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrAlu, 1, T1r,     '0,       '0,       5'd0,  1, 0);
    add(0, IrAlu, 1, T2s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrAlu, 1, YIn,     '0,       16'h0004, 5'd0,  1, 0);
    add(1, IrAlu, 1, '0,      '0,       '0,       5'd0,  0, 0);  // clear during T4
    add(0, IrAlu, 1, '0,      '0,       '0,       5'd0,  0, 0);
    add(0, IrAlu, 1, T0s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrHlt, 1, T1r,     '0,       '0,       5'd0,  1, 0);
    add(0, IrHlt, 1, T2s,     '0,       '0,       5'd0,  1, 0);
    add(0, IrHlt, 1, '0,      '0,       '0,       5'd0,  1, 0);
    add(0, IrHlt, 1, '0,      '0,       '0,       5'd0,  0, 0);  // halted
    add(0, IrAlu, 1, '0,      '0,       '0,       5'd0,  0, 0);
    add(0, IrAlu, 1, '0,      '0,       '0,       5'd0,  0, 0);
    add(1, IrAlu, 1, '0,      '0,       '0,       5'd0,  0, 0);
    add(0, IrAlu, 1, '0,      '0,       '0,       5'd0,  0, 0);
    add(0, IrAlu, 1, T0s,     '0,       '0,       5'd0,  1, 0);

    clear = 1'b1;
    u_if.i_ir = '0;
    u_if.i_mem_ready = 1'b1;
    @(posedge clock);
    #1;
    foreach (vecs[i]) begin
      clear = vecs[i].clr;
      u_if.i_ir = vecs[i].ir;
      u_if.i_mem_ready = vecs[i].mr;
      #1;
      exp_o = {vecs[i].stb, vecs[i].rin, vecs[i].rout, vecs[i].alu, vecs[i].run, vecs[i].ill};
      act_o = actual();
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL row%0d: got stb=%h rin=%h rout=%h alu=%0d run=%b ill=%b, want stb=%h rin=%h rout=%h alu=%0d run=%b ill=%b",
                 i, act_o[52:39], act_o[38:23], act_o[22:7], act_o[6:2], act_o[1], act_o[0],
                 vecs[i].stb, vecs[i].rin, vecs[i].rout, vecs[i].alu, vecs[i].run, vecs[i].ill);
      end
      @(posedge clock);
      #1;
    end

    // Random legal stream: sync to the next T0, then time each instruction T0 to T0.
    u_if.i_mem_ready = 1'b1;
    u_if.i_ir = IrNop;
    n = 0;
    while (!u_if.o_pc_out && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (!u_if.o_pc_out) begin
      errors++;
      $display("FAIL sync: pc_out=%b after %0d cycles, required 1 within 20", u_if.o_pc_out, n);
    end

    for (int k = 0; k < 40; k++) begin
      cls = $urandom_range(0, 2);
      if (cls == 0) begin
        opc = $urandom_range(3, 12);
        base = 6;
      end else if (cls == 1) begin
        opc = ($urandom_range(0, 1) == 0) ? 15 : 16;
        base = 7;
      end else begin
        opc = 26;
        base = 4;
      end
      u_if.i_ir = mk_ir(opc, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      w = $urandom_range(0, 2);
      cnt = 0;
      do begin
        @(posedge clock);
        #1;
        cnt++;
        u_if.i_mem_ready = (cnt > w);
        #1;
        check_inv();
      end while (!u_if.o_pc_out && cnt < 20);
      checks++;
      if (cnt != base + w) begin
        errors++;
        $display("FAIL latency opc=%0d waits=%0d: got %0d cycles, required %0d",
                 opc, w, cnt, base + w);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
